// File: rtl/buddy_pkg.sv
// Shared types for the buddy-box arbiter: ownership FSM states and beeper patterns.
package buddy_pkg;

    typedef enum logic [1:0] {
        MASTER = 2'd0,
        HOLD   = 2'd1,
        SLAVE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PAT_IDLE   = 3'd0,
        PAT_SINGLE = 3'd1,
        PAT_FIRST  = 3'd2,
        PAT_GAP    = 3'd3,
        PAT_SECOND = 3'd4
    } beep_t;

endpackage

// File: rtl/stick_centre_det.sv
// Per-channel stick centre detector with hysteresis; 'centred' is the flag value
// being latched this cycle so the arbiter reacts in the same clock.
module stick_centre_det #(
    parameter int CH_W   = 11,
    parameter int CENTRE = 515,
    parameter int DB_IN  = 15,
    parameter int DB_OUT = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH_W-1:0] ch_val,
    output logic            centred
);

    localparam logic [CH_W:0] CENTRE_V = (CH_W+1)'(CENTRE);
    localparam logic [CH_W:0] DB_IN_V  = (CH_W+1)'(DB_IN);
    localparam logic [CH_W:0] DB_OUT_V = (CH_W+1)'(DB_OUT);

    logic [CH_W:0] val_s;
    logic [CH_W:0] dist_s;
    logic          centred_r;
    logic          centred_nxt_s;

    // Distance from centre, one bit wider than the channel so it never wraps.
    always_comb begin
        val_s = {1'b0, ch_val};
        if (val_s >= CENTRE_V) begin
            dist_s = val_s - CENTRE_V;
        end else begin
            dist_s = CENTRE_V - val_s;
        end
    end

    // Hysteresis: set inside the inner window, clear outside the outer one.
    always_comb begin
        centred_nxt_s = centred_r;
        if (dist_s <= DB_IN_V) begin
            centred_nxt_s = 1'b1;
        end else if (dist_s > DB_OUT_V) begin
            centred_nxt_s = 1'b0;
        end else begin
            centred_nxt_s = centred_r;
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            centred_r <= 1'b0;
        end else begin
            centred_r <= centred_nxt_s;
        end
    end

    assign centred = centred_nxt_s;

endmodule

// File: rtl/buddy_arbiter.sv
// Buddy-box arbiter: hands gated channels to the slave radio after the master
// sticks stay centred, with instant master takeover and a status beeper.
// Optional macro BUDDY_SLEW_EN rate-limits gated channels after handover.
module buddy_arbiter
    import buddy_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                CH_W       = 11,
    parameter int                CENTRE     = 515,
    parameter int                DB_IN      = 15,
    parameter int                DB_OUT     = 25,
    parameter logic [NUM_CH-1:0] GATE_MASK  = 4'b1011,
    parameter int                TICK_DIV   = 5_000_000,
    parameter int                HOLD_TICKS = 20,
    parameter int                BEEP_TICKS = 2,
    parameter int                SLEW_STEP  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*CH_W-1:0] master_ch,
    input  logic [NUM_CH*CH_W-1:0] slave_ch,
    input  logic                   slave_ok,
    output logic [NUM_CH*CH_W-1:0] ch_out,
    output logic                   slave_active,
    output logic                   buzzer
);

    localparam int PW       = $clog2(TICK_DIV + 1);
    localparam int HW       = $clog2(HOLD_TICKS + 1);
    localparam int BEEP_LEN = BEEP_TICKS * TICK_DIV;
    localparam int BW       = $clog2(BEEP_LEN + 1);

    logic [NUM_CH-1:0]      flag_s;
    logic                   go_s;
    logic [PW-1:0]          presc_r;
    logic                   tick_s;
    state_t                 state_r, state_nxt_s;
    logic [HW-1:0]          hold_cnt_r, hold_cnt_nxt_s;
    beep_t                  pat_r, pat_nxt_s;
    logic [BW-1:0]          beep_cnt_r, beep_cnt_nxt_s;
    logic [NUM_CH*CH_W-1:0] ch_sel_s, ch_nxt_s, ch_out_r;
    logic                   slave_active_r, buzzer_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stick_centre_det #(
            .CH_W  (CH_W),
            .CENTRE(CENTRE),
            .DB_IN (DB_IN),
            .DB_OUT(DB_OUT)
        ) u_det (
            .clk    (clk),
            .rst_n  (rst_n),
            .ch_val (master_ch[i*CH_W +: CH_W]),
            .centred(flag_s[i])
        );
    end

    assign go_s   = (&(flag_s | ~GATE_MASK)) & slave_ok;
    assign tick_s = (presc_r == PW'(TICK_DIV - 1));

    // Free-running tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Ownership FSM next state and hold counter.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            MASTER: begin
                hold_cnt_nxt_s = '0;
                if (go_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = MASTER;
                end
            end
            HOLD: begin
                if (!go_s) begin
                    state_nxt_s    = MASTER;
                    hold_cnt_nxt_s = '0;
                end else if (tick_s) begin
                    if (hold_cnt_r == HW'(HOLD_TICKS - 1)) begin
                        state_nxt_s    = SLAVE;
                        hold_cnt_nxt_s = HW'(HOLD_TICKS);
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + HW'(1);
                    end
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end
            SLAVE: begin
                if (!go_s) begin
                    state_nxt_s    = MASTER;
                    hold_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = SLAVE;
                end
            end
            default: begin
                state_nxt_s    = MASTER;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    // Beep sequencer; a new event always restarts from the first beep.
    always_comb begin
        pat_nxt_s      = pat_r;
        beep_cnt_nxt_s = beep_cnt_r;
        if (state_r != SLAVE && state_nxt_s == SLAVE) begin
            pat_nxt_s      = PAT_SINGLE;
            beep_cnt_nxt_s = '0;
        end else if (state_r == SLAVE && state_nxt_s != SLAVE) begin
            pat_nxt_s      = PAT_FIRST;
            beep_cnt_nxt_s = '0;
        end else if (pat_r == PAT_IDLE) begin
            beep_cnt_nxt_s = '0;
        end else if (beep_cnt_r == BW'(BEEP_LEN - 1)) begin
            beep_cnt_nxt_s = '0;
            case (pat_r)
                PAT_FIRST: pat_nxt_s = PAT_GAP;
                PAT_GAP:   pat_nxt_s = PAT_SECOND;
                default:   pat_nxt_s = PAT_IDLE;
            endcase
        end else begin
            beep_cnt_nxt_s = beep_cnt_r + BW'(1);
        end
    end

    // Source selection from the state being entered, giving one-clock latency.
    always_comb begin
        ch_sel_s = master_ch;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_nxt_s == SLAVE && GATE_MASK[i]) begin
                ch_sel_s[i*CH_W +: CH_W] = slave_ch[i*CH_W +: CH_W];
            end else begin
                ch_sel_s[i*CH_W +: CH_W] = master_ch[i*CH_W +: CH_W];
            end
        end
    end

`ifdef BUDDY_SLEW_EN
    logic [NUM_CH-1:0] trk_r, trk_nxt_s;

    function automatic logic [CH_W-1:0] slew_to(input logic [CH_W-1:0] cur,
                                                 input logic [CH_W-1:0] src);
        logic [CH_W-1:0] step_v;
        step_v = CH_W'(SLEW_STEP);
        if (src > cur) begin
            return ((src - cur) > step_v) ? (cur + step_v) : src;
        end else begin
            return ((cur - src) > step_v) ? (cur - step_v) : src;
        end
    endfunction

    // Gated channels ramp toward the slave after handover; master always bypasses.
    always_comb begin
        ch_nxt_s  = ch_sel_s;
        trk_nxt_s = trk_r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_nxt_s != SLAVE || !GATE_MASK[i]) begin
                trk_nxt_s[i] = 1'b1;
            end else if (state_r != SLAVE) begin
                trk_nxt_s[i]             = 1'b0;
                ch_nxt_s[i*CH_W +: CH_W] = ch_out_r[i*CH_W +: CH_W];
            end else if (trk_r[i] || ch_out_r[i*CH_W +: CH_W] == ch_sel_s[i*CH_W +: CH_W]) begin
                trk_nxt_s[i] = 1'b1;
            end else if (tick_s) begin
                ch_nxt_s[i*CH_W +: CH_W] = slew_to(ch_out_r[i*CH_W +: CH_W],
                                                   ch_sel_s[i*CH_W +: CH_W]);
            end else begin
                ch_nxt_s[i*CH_W +: CH_W] = ch_out_r[i*CH_W +: CH_W];
            end
        end
    end

    // Slew tracking flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_r <= '1;
        end else begin
            trk_r <= trk_nxt_s;
        end
    end
`else
    assign ch_nxt_s = ch_sel_s;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= MASTER;
            hold_cnt_r     <= '0;
            pat_r          <= PAT_IDLE;
            beep_cnt_r     <= '0;
            ch_out_r       <= {NUM_CH{CH_W'(CENTRE)}};
            slave_active_r <= 1'b0;
            buzzer_r       <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            hold_cnt_r     <= hold_cnt_nxt_s;
            pat_r          <= pat_nxt_s;
            beep_cnt_r     <= beep_cnt_nxt_s;
            ch_out_r       <= ch_nxt_s;
            slave_active_r <= (state_nxt_s == SLAVE);
            buzzer_r       <= (pat_nxt_s == PAT_SINGLE) || (pat_nxt_s == PAT_FIRST) ||
                              (pat_nxt_s == PAT_SECOND);
        end
    end

    assign ch_out       = ch_out_r;
    assign slave_active = slave_active_r;
    assign buzzer       = buzzer_r;

endmodule

// File: doc/buddy_arbiter.md
BUDDY_ARBITER -- requirements
Module: buddy_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of RC channels per radio.
REQ-002 SHALL have parameter CH_W, default 11: bit width of each channel value, unsigned.
REQ-003 SHALL have parameter CENTRE, default 515: stick-centre value.
REQ-004 SHALL have parameter DB_IN, default 15: half-window in which a stick counts as centred while not yet centred.
REQ-005 SHALL have parameter DB_OUT, default 25 (DB_OUT >= DB_IN): half-window a centred stick must leave to count as moved.
REQ-006 SHALL have parameter GATE_MASK, default 4'b1011: channels whose centring is checked and which hand over to the slave; unmasked channels always pass master.
REQ-007 SHALL have parameter TICK_DIV, default 5_000_000: clk cycles per tick.
REQ-008 SHALL have parameter HOLD_TICKS, default 20: ticks of master centring before handover.
REQ-009 SHALL have parameter BEEP_TICKS, default 2: length of one beep and of one gap, in ticks.
REQ-010 SHALL have parameter SLEW_STEP, default 8: per-tick output step, used only with BUDDY_SLEW_EN.
REQ-011 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-012 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-013 SHALL have port master_ch, input, NUM_CH*CH_W bits: master radio channels, ch0 in the LSBs.
REQ-014 SHALL have port slave_ch, input, NUM_CH*CH_W bits: slave radio channels.
REQ-015 SHALL have port slave_ok, input, 1 bit: slave link valid.
REQ-016 SHALL have port ch_out, output, NUM_CH*CH_W bits: registered selected channels.
REQ-017 SHALL have port slave_active, output, 1 bit: high in state SLAVE.
REQ-018 SHALL have port buzzer, output, 1 bit: registered beep output.

Function
REQ-019 SHALL generate a one-cycle tick pulse every TICK_DIV clocks from a free-running prescaler.
REQ-020 SHALL keep a per-channel centred flag with hysteresis:
- flag sets when |master-CENTRE| <= DB_IN;
- flag clears when |master-CENTRE| > DB_OUT;
- flag holds otherwise;
- |x| is computed at CH_W+1 bits without wrap.
REQ-021 SHALL define all_centred as the AND of the flags of the GATE_MASK channels.
REQ-022 SHALL run FSM MASTER -> HOLD when all_centred = 1 and slave_ok = 1.
REQ-023 SHALL run FSM HOLD -> MASTER immediately on !all_centred or !slave_ok; otherwise the hold counter increments on tick.
REQ-024 SHALL run FSM HOLD -> SLAVE when the hold counter reaches HOLD_TICKS.
REQ-025 SHALL run FSM SLAVE -> MASTER in one clock on !all_centred or !slave_ok; master takeover is never delayed by ticks.
REQ-026 SHALL, in SLAVE, select slave_ch for GATE_MASK channels and master_ch for all others; in MASTER and HOLD it SHALL select master_ch for every channel.
REQ-027 SHALL register ch_out one clock after the input and state change (latency 1).
REQ-028 SHALL play one beep of BEEP_TICKS ticks on entry to SLAVE.
REQ-029 SHALL play beep-gap-beep on SLAVE -> MASTER.
REQ-030 SHALL make a new pattern event abort any pattern in progress and restart.
REQ-031 SHALL make a takeover while the slave is lost (!slave_ok) play the two-beep pattern.

Reset
REQ-032 SHALL, while rst_n = 0, force the following:
- state MASTER;
- counters and prescaler 0;
- flags 0;
- ch_out = CENTRE on every channel;
- slave_active = 0;
- buzzer = 0.
REQ-033 SHALL, on reset mid-HOLD or mid-SLAVE, discard the hold progress and any beep pattern with no residual output.

Configuration
REQ-034 SHALL, with BUDDY_SLEW_EN defined, move each gated ch_out by at most SLEW_STEP per tick toward its selected source after an ownership change, and track the source directly once equal.
REQ-035 SHALL, with BUDDY_SLEW_EN defined, make takeover to MASTER bypass the slew and output master values the next clock.
REQ-036 SHALL, without BUDDY_SLEW_EN, switch ownership with no slew logic.

Structure
REQ-037 SHALL place the state enum (MASTER, HOLD, SLAVE) and the beep pattern enum in package buddy_pkg.
REQ-038 SHALL implement the hysteresis centre detector as sub-module stick_centre_det, one instance per channel.

Verification
(NUM_CH = 4, CH_W = 11, TICK_DIV = 10, HOLD_TICKS = 20, BEEP_TICKS = 2)
REQ-039 SHALL verify that master at 515 on ch0/1/3 with slave_ok = 1 gives slave_active = 1 after 200 clocks, ch_out ch0 = slave value, ch2 = master value, and a 20-clock beep.
REQ-040 SHALL verify that in SLAVE, master ch1 = 541 gives slave_active = 0 and ch_out ch1 = 541 on the next clock, plus a two-beep pattern.
REQ-041 SHALL verify hysteresis: master ch0 = 535 after centring holds the flag; 541 clears it; returning to 535 does not set it; 530 sets it.
REQ-042 SHALL verify that in HOLD at tick 19, master ch3 = 560 sends the FSM to MASTER, and re-centring restarts the count from 0.
REQ-043 SHALL verify that in SLAVE, slave_ok = 0 gives MASTER next clock plus two beeps; rst_n low mid-beep gives buzzer = 0 and ch_out = 515 immediately.
REQ-044 SHALL verify, with BUDDY_SLEW_EN, master 515 -> slave 600: ch_out ch0 rises by 8 per tick to 600; takeover is immediate.
